// File: rtl/lsu_pkg.sv
// Shared LSU definitions: memory ALU codes, enable levels, FSM/size encodings and decode helpers.
package lsu_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT} lsu_state_e;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} lsu_size_e;

    function automatic logic is_load(input logic [5:0] code);
        return code inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    endfunction

    function automatic logic is_mem_op(input logic [5:0] code);
        return is_load(code) || (code inside {ALU_SB, ALU_SH, ALU_SW});
    endfunction

    function automatic logic is_unsigned(input logic [5:0] code);
        return code inside {ALU_LBU, ALU_LHU};
    endfunction

    function automatic lsu_size_e access_size(input logic [5:0] code);
        if (code inside {ALU_LB, ALU_LBU, ALU_SB}) return SIZE_BYTE;
        if (code inside {ALU_LH, ALU_LHU, ALU_SH}) return SIZE_HALF;
        return SIZE_WORD;
    endfunction

    function automatic logic is_misaligned(input logic [5:0] code, input logic [1:0] off);
        case (access_size(code))
            SIZE_HALF: return off[0];
            SIZE_WORD: return off != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory port of the LSU: request/grant handshake with byte lanes and a load response.
interface lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables/replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [5:0]  alucode,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        store;

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        be        = 4'b0000;
        bus_wdata = '0;
        load_data = '0;
        store     = !is_load(alucode);
        byte_v    = rdata[{off, 3'b000} +: 8];
        half_v    = rdata[{off[1], 4'b0000} +: 16];
        case (access_size(alucode))
            SIZE_BYTE: begin
                be        = 4'b0001 << off;
                bus_wdata = store ? {4{wdata[7:0]}} : '0;
                load_data = is_unsigned(alucode) ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SIZE_HALF: begin
                be        = 4'b0011 << {off[1], 1'b0};
                bus_wdata = store ? {2{wdata[15:0]}} : '0;
                load_data = is_unsigned(alucode) ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                be        = 4'b1111;
                bus_wdata = store ? wdata : '0;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory access at a time, response timeout, extended load return.
// Optional misaligned-access trap is built when LSU_MISALIGN_TRAP_EN is defined.
module lsu
    import lsu_pkg::*;
#(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misaligned_o,
`endif
    lsu_if.master       dmem
);
    localparam int CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    lsu_state_e      state;
    logic [5:0]      code_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [CW-1:0]   cnt;
    logic [3:0]      be_c;
    logic [31:0]     wdata_c;
    logic [31:0]     load_data;
    logic            in_req;
    logic            load_q;
    logic            accept;
    logic            finish;
    logic            timeout;

    lsu_align u_align (
        .alucode   (code_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (dmem.rdata),
        .be        (be_c),
        .bus_wdata (wdata_c),
        .load_data (load_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    // The trap response cycle keeps the FSM in IDLE but must still refuse new work.
    assign ready_o = (state == LSU_IDLE) && !misaligned_o;
`else
    assign ready_o = (state == LSU_IDLE);
`endif

    assign in_req  = (state == LSU_REQ);
    assign load_q  = is_load(code_q);
    assign accept  = ready_o && valid_i && is_mem_op(alucode);
    assign finish  = (in_req && dmem.gnt && !load_q) || ((state == LSU_WAIT) && dmem.rvalid);
    // A transaction that completes on its last allowed cycle wins over the abort.
    assign timeout = (RESP_TIMEOUT != 0) && (state != LSU_IDLE) && !finish
                     && (cnt == CW'(RESP_TIMEOUT - 1));

    assign dmem.req   = in_req;
    assign dmem.we    = in_req ? !load_q : DISABLE;
    assign dmem.addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign dmem.be    = in_req ? be_c : 4'b0000;
    assign dmem.wdata = in_req ? wdata_c : '0;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LSU_IDLE;
            code_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            done_o  <= DISABLE;
            err_o   <= DISABLE;
            rdata_o <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_o <= DISABLE;
`endif
        end else begin
            done_o  <= DISABLE;
            err_o   <= DISABLE;
            rdata_o <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_o <= DISABLE;
`endif
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        code_q  <= alucode;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        cnt     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (is_misaligned(alucode, addr_i[1:0])) begin
                            done_o       <= ENABLE;
                            misaligned_o <= ENABLE;
                        end else begin
                            state <= LSU_REQ;
                        end
`else
                        state <= LSU_REQ;
`endif
                    end
                end
                LSU_REQ, LSU_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (finish) begin
                        state  <= LSU_IDLE;
                        done_o <= ENABLE;
                        if (state == LSU_WAIT) rdata_o <= load_data;
                    end else if (timeout) begin
                        state  <= LSU_IDLE;
                        done_o <= ENABLE;
                        err_o  <= ENABLE;
                    end else if (in_req && dmem.gnt) begin
                        state <= LSU_WAIT;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized loads/stores against a byte-lane model.
module tb_lsu;
    import lsu_pkg::*;

    localparam int TO_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [5:0]  alucode;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o, done_o, err_o;
    logic [31:0] rdata_o;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misaligned_o, misal2;
`endif
    logic        valid2;
    logic [5:0]  code2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        ready2, done2, err2;

    lsu_if dmem ();
    lsu_if dmem2 ();

    int checks = 0;
    int errors = 0;
    int ops_exp = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk (clk), .rst_n (rst_n), .valid_i (valid_i), .alucode (alucode),
        .addr_i (addr_i), .wdata_i (wdata_i), .ready_o (ready_o), .done_o (done_o),
        .rdata_o (rdata_o), .err_o (err_o),
`ifdef LSU_MISALIGN_TRAP_EN
        .misaligned_o (misaligned_o),
`endif
        .dmem (dmem)
    );

    lsu #(.RESP_TIMEOUT(TO_CYC)) dut_to (
        .clk (clk), .rst_n (rst_n), .valid_i (valid2), .alucode (code2),
        .addr_i (addr2), .wdata_i (wdata2), .ready_o (ready2), .done_o (done2),
        .rdata_o (rdata2), .err_o (err2),
`ifdef LSU_MISALIGN_TRAP_EN
        .misaligned_o (misal2),
`endif
        .dmem (dmem2)
    );

    always @(negedge clk) if (done_o) done_seen++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: access size in bytes and lane arithmetic
    function automatic int m_size(input logic [5:0] c);
        if (c == ALU_LB || c == ALU_LBU || c == ALU_SB) return 1;
        if (c == ALU_LH || c == ALU_LHU || c == ALU_SH) return 2;
        return 4;
    endfunction

    function automatic bit m_load(input logic [5:0] c);
        return c == ALU_LB || c == ALU_LH || c == ALU_LW || c == ALU_LBU || c == ALU_LHU;
    endfunction

    function automatic logic [31:0] m_be(input logic [5:0] c, input int off);
        if (m_size(c) == 1) return 32'(1 << off);
        if (m_size(c) == 2) return (off >= 2) ? 32'hC : 32'h3;
        return 32'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] c, input logic [31:0] wd);
        if (m_load(c)) return 32'h0;
        if (m_size(c) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (m_size(c) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [5:0] c, input int off, input logic [31:0] rd);
        logic [31:0] v;
        if (m_size(c) == 1) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (c == ALU_LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (m_size(c) == 2) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (c == ALU_LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One complete transaction on the main DUT: grant after g REQ cycles, rvalid after r WAIT cycles.
    task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] wd,
                          input int g, input int r, input logic [31:0] bus_rd);
        bit ld;
        int off;
        ld  = m_load(c);
        off = int'(a[1:0]);
        @(negedge clk);
        check("idle_ready", 32'(ready_o), 1);
        check("done_pulse_len", 32'(done_o), 0);
        valid_i = 1'b1; alucode = c; addr_i = a; wdata_i = wd;
        @(negedge clk);
        valid_i = 1'b0; alucode = 6'($urandom); addr_i = $urandom; wdata_i = $urandom;
        for (int k = 0; k <= g; k++) begin
            check("req", 32'(dmem.req), 1);
            check("we", 32'(dmem.we), ld ? 0 : 1);
            check("addr", dmem.addr, a & 32'hFFFF_FFFC);
            check("be", 32'(dmem.be), m_be(c, off));
            check("wdata", dmem.wdata, m_wdata(c, wd));
            check("busy_ready", 32'(ready_o), 0);
            check("busy_done", 32'(done_o), 0);
            dmem.gnt    = (k == g);
            dmem.rvalid = (k != g) ? 1'($urandom) : 1'b0;
            dmem.rdata  = $urandom;
            @(negedge clk);
        end
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
        if (ld) begin
            for (int k = 0; k <= r; k++) begin
                check("wait_req", 32'(dmem.req), 0);
                check("wait_done", 32'(done_o), 0);
                dmem.rvalid = (k == r);
                dmem.rdata  = (k == r) ? bus_rd : $urandom;
                @(negedge clk);
            end
            dmem.rvalid = 1'b0;
        end
        check("done", 32'(done_o), 1);
        check("err", 32'(err_o), 0);
        if (ld) check("rdata", rdata_o, m_rdata(c, off, bus_rd));
        ops_exp++;
    endtask

    logic [5:0]  mem_codes [8];
    logic [5:0]  rc;
    logic [31:0] ra;
    int          n;

    initial begin
        mem_codes = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};
        rst_n = 1'b0; valid_i = 1'b0; alucode = '0; addr_i = '0; wdata_i = '0;
        valid2 = 1'b0; code2 = '0; addr2 = '0; wdata2 = '0;
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
        dmem2.gnt = 1'b0; dmem2.rvalid = 1'b0; dmem2.rdata = '0;
        repeat (2) @(negedge clk);

        check("rst_ready", 32'(ready_o), 1);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_req", 32'(dmem.req), 0);
        check("rst_we", 32'(dmem.we), 0);
        check("rst_addr", dmem.addr, 0);
        check("rst_be", 32'(dmem.be), 0);
        check("rst_wdata", dmem.wdata, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("rst_misal", 32'(misaligned_o), 0);
`endif
        rst_n = 1'b1;

        // Directed cases from the byte-lane rules.
        run_op(ALU_SB, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0);
        run_op(ALU_LB, 32'h0000_2001, 32'h0, 0, 0, 32'h0000_8000);
        run_op(ALU_LBU, 32'h0000_2001, 32'h0, 0, 0, 32'h0000_8000);
        run_op(ALU_LH, 32'h0000_2002, 32'h0, 3, 1, 32'h8001_1234);
        run_op(ALU_SH, 32'h0000_2002, 32'h1234_BEEF, 1, 0, 32'h0);
`ifndef LSU_MISALIGN_TRAP_EN
        run_op(ALU_LW, 32'h0000_3002, 32'h0, 0, 0, 32'hDEAD_BEEF);
`endif

        // A non-memory code is ignored.
        @(negedge clk);
        valid_i = 1'b1; alucode = 6'd0; addr_i = 32'h0000_7000;
        @(negedge clk);
        valid_i = 1'b0;
        check("nonmem_req", 32'(dmem.req), 0);
        check("nonmem_ready", 32'(ready_o), 1);

        // Back-to-back: SW accepted in the load's done cycle.
        @(negedge clk);
        valid_i = 1'b1; alucode = ALU_LW; addr_i = 32'h0000_6008;
        @(negedge clk);
        valid_i = 1'b0;
        check("b2b_req1", 32'(dmem.req), 1);
        dmem.gnt = 1'b1;
        @(negedge clk);
        dmem.gnt = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'h1357_9BDF;
        @(negedge clk);
        dmem.rvalid = 1'b0;
        check("b2b_done1", 32'(done_o), 1);
        check("b2b_rdata1", rdata_o, 32'h1357_9BDF);
        check("b2b_ready", 32'(ready_o), 1);
        valid_i = 1'b1; alucode = ALU_SW; addr_i = 32'h0000_600C; wdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        valid_i = 1'b0;
        check("b2b_req2", 32'(dmem.req), 1);
        check("b2b_we2", 32'(dmem.we), 1);
        check("b2b_addr2", dmem.addr, 32'h0000_600C);
        check("b2b_wdata2", dmem.wdata, 32'hCAFE_F00D);
        check("b2b_nodone", 32'(done_o), 0);
        dmem.gnt = 1'b1;
        @(negedge clk);
        dmem.gnt = 1'b0;
        check("b2b_done2", 32'(done_o), 1);
        ops_exp += 2;

`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        valid_i = 1'b1; alucode = ALU_LW; addr_i = 32'h0000_3002;
        @(negedge clk);
        valid_i = 1'b0;
        check("mis_req", 32'(dmem.req), 0);
        check("mis_done", 32'(done_o), 1);
        check("mis_flag", 32'(misaligned_o), 1);
        check("mis_rdata", rdata_o, 0);
        check("mis_ready", 32'(ready_o), 0);
        @(negedge clk);
        check("mis_after_done", 32'(done_o), 0);
        check("mis_after_ready", 32'(ready_o), 1);
        ops_exp++;
`endif

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            rc = mem_codes[$urandom_range(0, 7)];
            ra = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
            ra = ra & ~32'(m_size(rc) - 1);
`endif
            run_op(rc, ra, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
        end

        // Reset in REQ and in WAIT: bus request drops and the unit is ready at once.
        @(negedge clk);
        valid_i = 1'b1; alucode = ALU_LW; addr_i = 32'h0000_4000;
        @(negedge clk);
        valid_i = 1'b0;
        check("pre_rst_req", 32'(dmem.req), 1);
        #1 rst_n = 1'b0;
        #1 check("rst_req_drop", 32'(dmem.req), 0);
        check("rst_req_ready", 32'(ready_o), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        valid_i = 1'b1; alucode = ALU_LHU; addr_i = 32'h0000_4002;
        @(negedge clk);
        valid_i = 1'b0; dmem.gnt = 1'b1;
        @(negedge clk);
        dmem.gnt = 1'b0;
        check("wait_busy", 32'(ready_o), 0);
        #1 rst_n = 1'b0;
        #1 check("rst_wait_ready", 32'(ready_o), 1);
        check("rst_wait_req", 32'(dmem.req), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_done", 32'(done_o), 0);
        check("done_count", 32'(done_seen), 32'(ops_exp));

        // Timeout on the short-timeout instance: store never granted.
        @(negedge clk);
        valid2 = 1'b1; code2 = ALU_SW; addr2 = 32'h0000_5000; wdata2 = 32'h1111_2222;
        @(negedge clk);
        valid2 = 1'b0;
        n = 0;
        while (!done2 && n < 20) begin
            check("to_st_req", 32'(dmem2.req), 1);
            @(negedge clk);
            n++;
        end
        check("to_st_lat", 32'(n), TO_CYC);
        check("to_st_err", 32'(err2), 1);

        // Timeout on a load granted at once with no response, then stray bus activity in IDLE.
        @(negedge clk);
        valid2 = 1'b1; code2 = ALU_LW; addr2 = 32'h0000_5004;
        @(negedge clk);
        valid2 = 1'b0; dmem2.gnt = 1'b1;
        n = 0;
        while (!done2 && n < 20) begin
            @(negedge clk);
            dmem2.gnt = 1'b0;
            n++;
        end
        check("to_ld_lat", 32'(n), TO_CYC);
        check("to_ld_err", 32'(err2), 1);
        check("to_ld_rdata", rdata2, 0);
        check("to_ld_ready", 32'(ready2), 1);
        dmem2.rvalid = 1'b1; dmem2.gnt = 1'b1; dmem2.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem2.rvalid = 1'b0; dmem2.gnt = 1'b0;
        check("stray_done", 32'(done2), 0);
        check("stray_err", 32'(err2), 0);
        check("stray_req", 32'(dmem2.req), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the execute→memory path of the RV32 core. It consumes the memory-class ALU codes and the effective address produced by the ALU (`alu_result` = op1 + op2). It drives a request/grant/response data-memory port with byte lanes, then returns sign- or zero-extended load data to writeback. It runs one transaction at a time and stalls the pipeline through `ready_o` while busy.

## Interface
Parameters:
- `RESP_TIMEOUT`, default 255: maximum cycles spent in REQ+WAIT before the access is aborted with `err_o`; 0 disables the timeout.

Ports:
- `clk`, in, 1: single clock. Reset is asynchronous and active-low.
- `rst_n`, in, 1: asynchronous active-low reset.
- `valid_i`, in, 1: the execute stage presents an operation.
- `alucode`, in, 6: ALU code; only the `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW` codes are acted on.
- `addr_i`, in, 32: effective address from the ALU.
- `wdata_i`, in, 32: store data (rs2 value).
- `ready_o`, out, 1: LSU is idle and can accept an operation.
- `done_o`, out, 1: one-cycle completion pulse.
- `rdata_o`, out, 32: extended load data; valid only with `done_o` on a load.
- `err_o`, out, 1: timeout abort; qualified by `done_o`.
- `misaligned_o`, out, 1: misaligned access; qualified by `done_o`. Present only with `LSU_MISALIGN_TRAP_EN`.
- `dmem_req`, out, 1: bus request.
- `dmem_we`, out, 1: 1 for store, 0 for load.
- `dmem_addr`, out, 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_be`, out, 4: byte enables.
- `dmem_wdata`, out, 32: lane-replicated store data.
- `dmem_gnt`, in, 1: request accepted this cycle.
- `dmem_rvalid`, in, 1: load data valid.
- `dmem_rdata`, in, 32: load data.

## Operation
- The FSM has states IDLE, REQ and WAIT. `ready_o = (state==IDLE)`.
- In IDLE, `valid_i` together with a memory-class `alucode` captures the code, address, byte offset `off=addr_i[1:0]` and data, then moves to REQ. A non-memory `alucode` is ignored and the state stays IDLE.
- In REQ, `dmem_req=1` and all `dmem_*` outputs stay stable until `dmem_gnt`.
  - A store with `dmem_gnt` returns to IDLE.
  - A load with `dmem_gnt` moves to WAIT.
- In WAIT, `dmem_rvalid` returns to IDLE. `dmem_rvalid` seen in REQ is ignored.
- Byte enables:
  - SB: `be = 4'b0001<<off`, `wdata = {4{wdata_i[7:0]}}`.
  - SH: `be = 4'b0011<<(off[1]*2)`, `wdata = {2{wdata_i[15:0]}}`.
  - SW: `be = 4'b1111`.
  - Loads: `be` is computed the same way; `dmem_wdata` = 0.
- Load extraction:
  - Byte = `dmem_rdata[8*off +: 8]`.
  - Half = `dmem_rdata[16*off[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Timeout: a counter clears on accept and increments each cycle in REQ/WAIT. When it reaches `RESP_TIMEOUT` (nonzero), the FSM returns to IDLE and pulses `done_o` with `err_o=1` and `rdata_o=0`. A later stray `dmem_gnt`/`dmem_rvalid` in IDLE is ignored.

## Timing
- Reset (async, immediate) values:
  - state = IDLE, `ready_o=1`.
  - `done_o`, `err_o`, `misaligned_o`, `rdata_o` = 0.
  - All `dmem_*` outputs = 0.
- Reset mid-transaction drops `dmem_req` at once; no `done_o` is produced.
- Accept at cycle 0 puts `dmem_req=1` at cycle 1.
- Store with `dmem_gnt` at cycle N gives `done_o` at N+1.
- Load with `dmem_rvalid` at cycle M gives `done_o` and `rdata_o` at M+1.
- Minimum latency: store 2 cycles, load 3 cycles.
- `done_o`, `rdata_o` and `err_o` are registered, each for exactly one cycle.
- `ready_o` is 1 in the `done_o` cycle, so a back-to-back operation may be accepted in that cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `off[0]=1`, and LW/SW with `off!=0`, issue no bus request.
  - The FSM stays IDLE, and the cycle after accept it pulses `done_o` with `misaligned_o=1` and `rdata_o=0`.
  - `ready_o` is 0 for that one cycle.
- Not defined:
  - The port is absent and there is no detection.
  - Halfword accesses ignore `off[0]`; word accesses ignore `off`.

## Structure
- The memory ALU codes and `ENABLE`/`DISABLE` come from the shared `define.sv`.
- Add to the shared header: the FSM state encoding (`LSU_IDLE/REQ/WAIT`) and the access-size encoding (byte/half/word).
- Sub-module `lsu_align`, combinational: computes `be` and `dmem_wdata` and the load extract/extend. The FSM, counter and registers stay in `lsu`.

## Test plan
- SB, `addr_i=0x1003`, `wdata_i=0xA5` → `dmem_addr=0x1000`, `be=4'b1000`, `wdata=0xA5A5A5A5`; with `gnt` at cycle 1, `done_o` at cycle 2.
- LB at `0x2001` with `dmem_rdata=0x0000_8000` → `rdata_o=0xFFFF_FF80`. LBU at the same address → `0x0000_0080`.
- LH at `0x2002` with `rdata=0x8001_1234` → `rdata_o=0xFFFF_8001`. `gnt` withheld 3 cycles → `dmem_req` and `addr` stay stable throughout.
- Load, then a new SW accepted in the `done_o` cycle → second `dmem_req` the following cycle; no dropped or duplicated `done_o`.
- `RESP_TIMEOUT=4`, `rvalid` never arrives → `done_o=1`, `err_o=1` exactly 4 cycles after REQ entry; a late `rvalid` in IDLE is ignored.
- With the macro, LW at `0x3002` → no `dmem_req`, `done_o` and `misaligned_o` the next cycle. Without the macro → `be=4'b1111`, `dmem_addr=0x3000`. Async reset in WAIT → `dmem_req=0` and `ready_o=1` immediately.
